// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes, mux selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_ALU_WB   = 4'd8,
    S_IMM_EX   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Where DECODE sends each opcode; unsupported opcodes fall back to FETCH.
  function automatic state_t dispatch(input logic [5:0] op);
    case (op)
      OP_RTYPE:                                  dispatch = S_RTYPE_EX;
      OP_LW, OP_SW:                              dispatch = S_MEMADR;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: dispatch = S_IMM_EX;
      OP_BEQ, OP_BNE:                            dispatch = S_BRANCH;
      OP_J:                                      dispatch = S_JUMP;
      default:                                   dispatch = S_FETCH;
    endcase
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
    op_legal = (dispatch(op) != S_FETCH);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS datapath (fetch/decode/execute/memory/writeback).
// Latency: R-type/imm 4, lw 5, sw 4, branch/jump 3 cycles, plus one per memory wait cycle.
// Backpressure: FETCH, MEMRD and MEMWR hold their strobes until i_mem_ready.
module multicycle_control
  import mips_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_Op,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_MemRead,
  output logic       o_MemWrite,
  output logic       o_IorD,
  output logic       o_IRWrite,
  output logic       o_PCWrite,
  output logic       o_RegWrite,
  output logic       o_RegDst,
  output logic       o_MemtoReg,
  output logic       o_ALUSrcA,
  output logic [1:0] o_ALUSrcB,
  output logic [1:0] o_ALUOp,
  output logic [1:0] o_PCSource,
  output logic       o_retire,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;

  // State and latched-opcode registers; reset aborts any pending access.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_RESET;
      op_q    <= OP_RTYPE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next state; DECODE dispatches on the opcode it is latching this cycle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_RESET:    state_d = S_FETCH;
      S_FETCH:    if (i_mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d    = i_Op;
        state_d = dispatch(i_Op);
      end
      S_MEMADR:   state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    if (i_mem_ready) state_d = S_MEMWB;
      S_MEMWR:    if (i_mem_ready) state_d = S_FETCH;
      S_MEMWB:    state_d = S_FETCH;
      S_RTYPE_EX: state_d = S_ALU_WB;
      S_IMM_EX:   state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_RESET;
    endcase
  end

  // Output decode; anything not named for a state stays 0.
  always_comb begin
    o_MemRead  = 1'b0;
    o_MemWrite = 1'b0;
    o_IorD     = 1'b0;
    o_IRWrite  = 1'b0;
    o_PCWrite  = 1'b0;
    o_RegWrite = 1'b0;
    o_RegDst   = 1'b0;
    o_MemtoReg = 1'b0;
    o_ALUSrcA  = 1'b0;
    o_ALUSrcB  = SRCB_RT;
    o_ALUOp    = ALUOP_ADD;
    o_PCSource = PCSRC_ALU;
    o_retire   = 1'b0;
    o_illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        o_MemRead = 1'b1;
        o_ALUSrcB = SRCB_FOUR;
        o_IRWrite = i_mem_ready;
        o_PCWrite = i_mem_ready;
      end
      S_DECODE: begin
        o_ALUSrcB = SRCB_IMMSH;
        o_illegal = !op_legal(i_Op);
      end
      S_MEMADR: begin
        o_ALUSrcA = 1'b1;
        o_ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        o_MemRead = 1'b1;
        o_IorD    = 1'b1;
      end
      S_MEMWR: begin
        o_MemWrite = 1'b1;
        o_IorD     = 1'b1;
        o_retire   = i_mem_ready;
      end
      S_MEMWB: begin
        o_RegWrite = 1'b1;
        o_MemtoReg = 1'b1;
        o_retire   = 1'b1;
      end
      S_RTYPE_EX: begin
        o_ALUSrcA = 1'b1;
        o_ALUOp   = ALUOP_FUNC;
      end
      S_IMM_EX: begin
        o_ALUSrcA = 1'b1;
        o_ALUSrcB = SRCB_IMM;
        o_ALUOp   = ALUOP_FUNC;
      end
      S_ALU_WB: begin
        o_RegWrite = 1'b1;
        o_RegDst   = (op_q == OP_RTYPE);
        o_retire   = 1'b1;
      end
      S_BRANCH: begin
        o_ALUSrcA  = 1'b1;
        o_ALUOp    = ALUOP_SUB;
        o_PCSource = PCSRC_ALUOUT;
        o_PCWrite  = ((op_q == OP_BEQ) && i_zero) || ((op_q == OP_BNE) && !i_zero);
        o_retire   = 1'b1;
      end
      S_JUMP: begin
        o_PCWrite  = 1'b1;
        o_PCSource = PCSRC_JUMP;
        o_retire   = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
// Latency: per-cycle state/output comparison against hand-computed vectors.
// Backpressure: i_mem_ready driven low in chosen cycles to stretch memory states.
module tb_multicycle_control;
  import mips_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [5:0] i_Op;
  logic       i_zero;
  logic       i_mem_ready;
  logic       o_MemRead, o_MemWrite, o_IorD, o_IRWrite, o_PCWrite, o_RegWrite;
  logic       o_RegDst, o_MemtoReg, o_ALUSrcA, o_retire, o_illegal;
  logic [1:0] o_ALUSrcB, o_ALUOp, o_PCSource;
  logic [3:0] o_state;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_control dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_Op(i_Op), .i_zero(i_zero),
    .i_mem_ready(i_mem_ready),
    .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite), .o_IorD(o_IorD),
    .o_IRWrite(o_IRWrite), .o_PCWrite(o_PCWrite), .o_RegWrite(o_RegWrite),
    .o_RegDst(o_RegDst), .o_MemtoReg(o_MemtoReg), .o_ALUSrcA(o_ALUSrcA),
    .o_ALUSrcB(o_ALUSrcB), .o_ALUOp(o_ALUOp), .o_PCSource(o_PCSource),
    .o_retire(o_retire), .o_illegal(o_illegal), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  // Bit order: MemRead MemWrite IorD IRWrite PCWrite RegWrite RegDst MemtoReg
  //            ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0] retire illegal
  logic [16:0] outs;
  assign outs = {o_MemRead, o_MemWrite, o_IorD, o_IRWrite, o_PCWrite, o_RegWrite,
                 o_RegDst, o_MemtoReg, o_ALUSrcA, o_ALUSrcB, o_ALUOp, o_PCSource,
                 o_retire, o_illegal};

  localparam logic [16:0] E_ZERO     = 17'b0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [16:0] E_FETCH_R  = 17'b1_0_0_1_1_0_0_0_0_01_00_00_0_0;
  localparam logic [16:0] E_FETCH_W  = 17'b1_0_0_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [16:0] E_DECODE   = 17'b0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [16:0] E_DEC_ILL  = 17'b0_0_0_0_0_0_0_0_0_11_00_00_0_1;
  localparam logic [16:0] E_RTYPE    = 17'b0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [16:0] E_IMM      = 17'b0_0_0_0_0_0_0_0_1_10_10_00_0_0;
  localparam logic [16:0] E_WB_R     = 17'b0_0_0_0_0_1_1_0_0_00_00_00_1_0;
  localparam logic [16:0] E_WB_I     = 17'b0_0_0_0_0_1_0_0_0_00_00_00_1_0;
  localparam logic [16:0] E_MEMADR   = 17'b0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [16:0] E_MEMRD    = 17'b1_0_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [16:0] E_MEMWB    = 17'b0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [16:0] E_MEMWR_W  = 17'b0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [16:0] E_MEMWR_R  = 17'b0_1_1_0_0_0_0_0_0_00_00_00_1_0;
  localparam logic [16:0] E_BR_T     = 17'b0_0_0_0_1_0_0_0_1_00_01_01_1_0;
  localparam logic [16:0] E_BR_N     = 17'b0_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [16:0] E_JUMP     = 17'b0_0_0_0_1_0_0_0_0_00_00_10_1_0;

  // Per-scenario table: expected state, expected outputs, i_mem_ready to drive.
  state_t      tab_st  [8];
  logic [16:0] tab_ex  [8];
  logic        tab_rdy [8];

  task automatic row(input int i, input state_t st, input logic [16:0] ex, input logic rdy);
    tab_st[i]  = st;
    tab_ex[i]  = ex;
    tab_rdy[i] = rdy;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_Op = 6'b0; i_zero = 1'b0; i_mem_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk); #1;
    n_checks++;
    if (o_state !== S_RESET) begin
      n_errors++; $display("FAIL reset_state: got %0d want %0d", o_state, S_RESET);
    end
    n_checks++;
    if (outs !== E_ZERO) begin
      n_errors++; $display("FAIL reset_outs: got %b want %b", outs, E_ZERO);
    end
    i_rst_n = 1'b1;
  endtask

  task automatic test_add();
    int rets = 0;
    i_Op = OP_RTYPE;
    row(0, S_FETCH, E_FETCH_R, 1'b1); row(1, S_DECODE, E_DECODE, 1'b0);
    row(2, S_RTYPE_EX, E_RTYPE, 1'b0); row(3, S_ALU_WB, E_WB_R, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk); i_mem_ready = tab_rdy[i]; #1;
      n_checks++;
      if (o_state !== tab_st[i]) begin
        n_errors++; $display("FAIL add_state[%0d]: got %0d want %0d", i, o_state, tab_st[i]);
      end
      n_checks++;
      if (outs !== tab_ex[i]) begin
        n_errors++; $display("FAIL add_outs[%0d]: got %b want %b", i, outs, tab_ex[i]);
      end
      if (o_retire) rets++;
    end
    n_checks++;
    if (rets !== 1) begin
      n_errors++; $display("FAIL add_retire_count: got %0d want 1", rets);
    end
  endtask

  task automatic test_imm();
    i_Op = OP_ORI;
    row(0, S_FETCH, E_FETCH_R, 1'b1); row(1, S_DECODE, E_DECODE, 1'b1);
    row(2, S_IMM_EX, E_IMM, 1'b1); row(3, S_ALU_WB, E_WB_I, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk); i_mem_ready = tab_rdy[i]; #1;
      n_checks++;
      if (o_state !== tab_st[i]) begin
        n_errors++; $display("FAIL imm_state[%0d]: got %0d want %0d", i, o_state, tab_st[i]);
      end
      n_checks++;
      if (outs !== tab_ex[i]) begin
        n_errors++; $display("FAIL imm_outs[%0d]: got %b want %b", i, outs, tab_ex[i]);
      end
    end
  endtask

  task automatic test_lw_wait();
    int rets = 0;
    i_Op = OP_LW;
    row(0, S_FETCH, E_FETCH_R, 1'b1); row(1, S_DECODE, E_DECODE, 1'b0);
    row(2, S_MEMADR, E_MEMADR, 1'b0); row(3, S_MEMRD, E_MEMRD, 1'b0);
    row(4, S_MEMRD, E_MEMRD, 1'b0); row(5, S_MEMRD, E_MEMRD, 1'b1);
    row(6, S_MEMWB, E_MEMWB, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge i_clk); i_mem_ready = tab_rdy[i]; #1;
      n_checks++;
      if (o_state !== tab_st[i]) begin
        n_errors++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, o_state, tab_st[i]);
      end
      n_checks++;
      if (outs !== tab_ex[i]) begin
        n_errors++; $display("FAIL lw_outs[%0d]: got %b want %b", i, outs, tab_ex[i]);
      end
      n_checks++;
      if (o_MemRead && o_MemWrite) begin
        n_errors++; $display("FAIL lw_strobe_excl[%0d]: got both strobes want at most one", i);
      end
      if (o_retire) rets++;
    end
    n_checks++;
    if (rets !== 1) begin
      n_errors++; $display("FAIL lw_retire_count: got %0d want 1", rets);
    end
  endtask

  task automatic test_sw();
    i_Op = OP_SW;
    row(0, S_FETCH, E_FETCH_R, 1'b1); row(1, S_DECODE, E_DECODE, 1'b1);
    row(2, S_MEMADR, E_MEMADR, 1'b1); row(3, S_MEMWR, E_MEMWR_R, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk); i_mem_ready = tab_rdy[i]; #1;
      n_checks++;
      if (o_state !== tab_st[i]) begin
        n_errors++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, o_state, tab_st[i]);
      end
      n_checks++;
      if (outs !== tab_ex[i]) begin
        n_errors++; $display("FAIL sw_outs[%0d]: got %b want %b", i, outs, tab_ex[i]);
      end
    end
  endtask

  task automatic test_branch();
    i_zero = 1'b1;
    for (int b = 0; b < 2; b++) begin
      i_Op = (b == 0) ? OP_BEQ : OP_BNE;
      row(0, S_FETCH, E_FETCH_R, 1'b1); row(1, S_DECODE, E_DECODE, 1'b1);
      row(2, S_BRANCH, (b == 0) ? E_BR_T : E_BR_N, 1'b1);
      for (int i = 0; i < 3; i++) begin
        @(negedge i_clk); i_mem_ready = tab_rdy[i]; #1;
        n_checks++;
        if (o_state !== tab_st[i]) begin
          n_errors++; $display("FAIL branch%0d_state[%0d]: got %0d want %0d", b, i, o_state, tab_st[i]);
        end
        n_checks++;
        if (outs !== tab_ex[i]) begin
          n_errors++; $display("FAIL branch%0d_outs[%0d]: got %b want %b", b, i, outs, tab_ex[i]);
        end
      end
    end
    i_zero = 1'b0;
  endtask

  task automatic test_jump();
    i_Op = OP_J;
    row(0, S_FETCH, E_FETCH_R, 1'b1); row(1, S_DECODE, E_DECODE, 1'b1);
    row(2, S_JUMP, E_JUMP, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk); i_mem_ready = tab_rdy[i]; #1;
      n_checks++;
      if (o_state !== tab_st[i]) begin
        n_errors++; $display("FAIL jump_state[%0d]: got %0d want %0d", i, o_state, tab_st[i]);
      end
      n_checks++;
      if (outs !== tab_ex[i]) begin
        n_errors++; $display("FAIL jump_outs[%0d]: got %b want %b", i, outs, tab_ex[i]);
      end
    end
  endtask

  task automatic test_illegal();
    int bad = 0;
    i_Op = 6'b111111;
    row(0, S_FETCH, E_FETCH_R, 1'b1); row(1, S_DECODE, E_DEC_ILL, 1'b0);
    row(2, S_FETCH, E_FETCH_W, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk); i_mem_ready = tab_rdy[i]; #1;
      n_checks++;
      if (o_state !== tab_st[i]) begin
        n_errors++; $display("FAIL illegal_state[%0d]: got %0d want %0d", i, o_state, tab_st[i]);
      end
      n_checks++;
      if (outs !== tab_ex[i]) begin
        n_errors++; $display("FAIL illegal_outs[%0d]: got %b want %b", i, outs, tab_ex[i]);
      end
      if (o_RegWrite || o_MemWrite || o_retire) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_errors++; $display("FAIL illegal_side_effects: got %0d cycles want 0", bad);
    end
  endtask

  task automatic test_reset_in_memwr();
    i_Op = OP_SW;
    row(0, S_FETCH, E_FETCH_R, 1'b1); row(1, S_DECODE, E_DECODE, 1'b0);
    row(2, S_MEMADR, E_MEMADR, 1'b0); row(3, S_MEMWR, E_MEMWR_W, 1'b0);
    row(4, S_MEMWR, E_MEMWR_W, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk); i_mem_ready = tab_rdy[i]; #1;
      n_checks++;
      if (o_state !== tab_st[i]) begin
        n_errors++; $display("FAIL rstwr_state[%0d]: got %0d want %0d", i, o_state, tab_st[i]);
      end
      n_checks++;
      if (outs !== tab_ex[i]) begin
        n_errors++; $display("FAIL rstwr_outs[%0d]: got %b want %b", i, outs, tab_ex[i]);
      end
    end
    // Reset while the store is still waiting; memory completes at the same time.
    i_rst_n = 1'b0;
    @(negedge i_clk); i_mem_ready = 1'b1; #1;
    n_checks++;
    if (o_state !== S_RESET) begin
      n_errors++; $display("FAIL rstwr_abort_state: got %0d want %0d", o_state, S_RESET);
    end
    n_checks++;
    if (outs !== E_ZERO) begin
      n_errors++; $display("FAIL rstwr_abort_outs: got %b want %b", outs, E_ZERO);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk); i_mem_ready = 1'b0; #1;
    n_checks++;
    if (o_state !== S_FETCH) begin
      n_errors++; $display("FAIL rstwr_release_state: got %0d want %0d", o_state, S_FETCH);
    end
    n_checks++;
    if (outs !== E_FETCH_W) begin
      n_errors++; $display("FAIL rstwr_release_outs: got %b want %b", outs, E_FETCH_W);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_lw_wait();
    test_sw();
    test_branch();
    test_jump();
    test_illegal();
    test_reset_in_memwr();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL: i_clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL: i_rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL: i_Op  input  6  opcode field from the instruction register; valid from DECODE onward.
REQ-004 SHALL: i_zero  input  1  ALU zero flag; sampled in BRANCH only.
REQ-005 SHALL: i_mem_ready  input  1  memory access complete this cycle.
REQ-006 SHALL: o_MemRead / o_MemWrite  output  1 each  memory strobes, held until i_mem_ready.
REQ-007 SHALL: o_IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-008 SHALL: o_IRWrite / o_PCWrite / o_RegWrite  output  1 each  write enables.
REQ-009 SHALL: o_RegDst / o_MemtoReg  output  1 each  0 = rt / ALUOut, 1 = rd / MDR.
REQ-010 SHALL: o_ALUSrcA  output  1  0 = PC, 1 = rs.
REQ-011 SHALL: o_ALUSrcB  output  2  00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
REQ-012 SHALL: o_ALUOp  output  2  00 = force add, 01 = force sub, 10 = use the opcode/funct ALU decoder.
REQ-013 SHALL: o_PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-014 SHALL: o_retire  output  1  one-cycle pulse when an instruction completes.
REQ-015 SHALL: o_illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-016 SHALL: o_state  output  4  current state encoding, for debug.

Function
REQ-017 SHALL implement a Moore FSM with these states: RESET, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, ALU_WB, IMM_EX, BRANCH, JUMP.
REQ-018 SHALL, in RESET, drive all outputs to 0 and go to FETCH on the next cycle.
REQ-019 SHALL, in FETCH, assert MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01 and ALUOp=00.
- IRWrite and PCWrite (PCSource=00) are asserted only in the cycle i_mem_ready=1.
- The FSM remains in FETCH while i_mem_ready=0.
REQ-020 SHALL, in DECODE, assert ALUSrcA=0, ALUSrcB=11 and ALUOp=00 (branch target into ALUOut), and latch i_Op into an internal register.
REQ-021 SHALL dispatch from DECODE on the latched opcode:
- 000000 -> RTYPE_EX
- 100011 / 101011 -> MEMADR
- 001000, 001010, 001100, 001101, 001110 -> IMM_EX
- 000100 / 000101 -> BRANCH
- 000010 -> JUMP
- any other value -> FETCH, with o_illegal pulsed in the DECODE cycle.
REQ-022 SHALL, in MEMADR, drive ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state is MEMRD for lw, MEMWR for sw.
REQ-023 SHALL hold MEMRD (MemRead, IorD=1) and MEMWR (MemWrite, IorD=1) until i_mem_ready=1.
- MEMRD -> MEMWB.
- MEMWR -> FETCH, with o_retire in its ready cycle.
REQ-024 SHALL, in MEMWB, assert RegWrite, RegDst=0, MemtoReg=1 and o_retire; next state FETCH.
REQ-025 SHALL, in RTYPE_EX, drive ALUSrcA=1, ALUSrcB=00, ALUOp=10; in IMM_EX, drive ALUSrcA=1, ALUSrcB=10, ALUOp=10; both go to ALU_WB.
REQ-026 SHALL, in ALU_WB, assert RegWrite, MemtoReg=0 and o_retire, with RegDst=1 for R-type and 0 for immediate ops; next state FETCH.
REQ-027 SHALL, in BRANCH, drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, and assert PCWrite iff (beq AND i_zero) OR (bne AND NOT i_zero); o_retire; next state FETCH.
REQ-028 SHALL, in JUMP, assert PCWrite with PCSource=10 and o_retire; next state FETCH.
REQ-029 SHALL produce these latencies with zero memory wait: R-type/imm 4, lw 5, sw 4, branch 3, jump 3 cycles; each memory wait cycle adds exactly one cycle.
REQ-030 SHALL never assert MemRead and MemWrite together, and SHALL never assert o_retire and o_illegal together.
REQ-031 SHALL default every output not listed for a state to 0.

Reset
REQ-032 SHALL, when i_rst_n=0 at a rising edge, enter RESET regardless of state, aborting any pending memory access.
REQ-033 SHALL clear the latched opcode to 000000 on reset.
REQ-034 SHALL leave RESET on the first edge at which i_rst_n=1.

Structure
REQ-035 SHALL place the state enumeration, opcode constants and ALUOp/ALUSrcB/PCSource encodings in shared package mips_pkg.
REQ-036 SHALL be a single module with no sub-modules; the existing opcode/funct ALU decoder is instantiated beside it, not inside it.

Verification
REQ-037 SHALL cover: reset released, i_mem_ready=1, add (Op 000000) -> states FETCH, DECODE, RTYPE_EX, ALU_WB; RegWrite=1 and RegDst=1 in cycle 4; o_retire once.
REQ-038 SHALL cover: lw (100011) with i_mem_ready low for 2 cycles in MEMRD -> 7 cycles total; MemRead held throughout; MemtoReg=1 in MEMWB.
REQ-039 SHALL cover: beq with i_zero=1 -> PCWrite=1; bne with i_zero=1 -> PCWrite=0; both retire in 3 cycles.
REQ-040 SHALL cover: opcode 111111 -> o_illegal pulse in DECODE, next state FETCH, no RegWrite/MemWrite/o_retire.
REQ-041 SHALL cover: i_rst_n=0 asserted during MEMWR wait -> next cycle state RESET and all outputs 0; FETCH on the cycle after release.
